gpsdo_loop_sequencer: RTL

- Supervises the GPSDO disciplining loop between the phase measurement block and the PID filter.
- Qualifies each phase measurement and sequences the loop through warm-up, acquisition, tracking and lock.
- Selects the PID gain set and gates PID updates.
- Freezes the loop in holdover when PPS measurements stop arriving.

---
 rtl/gpsdo_loop_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/gpsdo_loop_sequencer.sv
// GPSDO loop sequencer: qualifies PPS phase measurements, walks the loop through
// warm-up, acquisition, tracking and lock, and freezes the PID in holdover.
module gpsdo_loop_sequencer #(
  parameter int WARMUP_CNT     = 4,
  parameter int ACQ_THRESH     = 1000,
  parameter int ACQ_COUNT      = 8,
  parameter int LOCK_THRESH    = 20,
  parameter int LOCK_COUNT     = 16,
  parameter int UNLOCK_THRESH  = 100,
  parameter int TIMEOUT_CYCLES = 15000000
) (
  input  logic        CLK_SYS,
  input  logic        CLK_RST,
  input  logic [23:0] Measure_Phase,
  input  logic        Measure_Done,
  output logic        Pid_Update,
  output logic [15:0] Phase_Err,
  output logic [1:0]  Pid_Gain_Sel,
  output logic        Pid_Hold,
  output logic        Led_Lock,
  output logic [2:0]  Loop_State
);

  localparam int RUN_MAX = (WARMUP_CNT > ACQ_COUNT)
                         ? ((WARMUP_CNT > LOCK_COUNT) ? WARMUP_CNT : LOCK_COUNT)
                         : ((ACQ_COUNT > LOCK_COUNT) ? ACQ_COUNT : LOCK_COUNT);
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RUN_W-1:0]   WARMUP_LIM = RUN_W'(WARMUP_CNT);
  localparam logic [RUN_W-1:0]   ACQ_N_LIM  = RUN_W'(ACQ_COUNT);
  localparam logic [RUN_W-1:0]   LOCK_N_LIM = RUN_W'(LOCK_COUNT);
  localparam logic [23:0]        ACQ_LIM    = 24'(ACQ_THRESH);
  localparam logic [23:0]        LOCK_LIM   = 24'(LOCK_THRESH);
  localparam logic [23:0]        UNLOCK_LIM = 24'(UNLOCK_THRESH);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_TRACK    = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_HOLDOVER = 3'd4
  } loop_state_t;

  loop_state_t        state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d, run_inc;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [23:0]        phase_mag;
  logic [15:0]        phase_sat;
  logic               update_d;
  logic               active_q, active_d;
  logic               timeout_hit;
  logic [1:0]         gain_d;

  // The most negative code has no positive twin, so it folds onto the largest magnitude.
  always_comb begin
    phase_mag = Measure_Phase;
    if (Measure_Phase == 24'h800000) begin
      phase_mag = 24'h7FFFFF;
    end else if (Measure_Phase[23]) begin
      phase_mag = ~Measure_Phase + 24'd1;
    end
  end

  always_comb begin
    phase_sat = Measure_Phase[15:0];
    if (!Measure_Phase[23] && (|Measure_Phase[22:15])) begin
      phase_sat = 16'h7FFF;
    end else if (Measure_Phase[23] && !(&Measure_Phase[22:15])) begin
      phase_sat = 16'h8000;
    end
  end

  assign run_inc     = run_q + 1'b1;
  assign active_q    = (state_q == ST_ACQUIRE) || (state_q == ST_TRACK) || (state_q == ST_LOCKED);
  assign timeout_hit = !Measure_Done && (timer_q == TIMER_LAST);

  always_comb begin
    timer_d = timer_q;
    if (Measure_Done) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // A strobe always takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    update_d = 1'b0;
    if (Measure_Done) begin
      case (state_q)
        ST_IDLE: begin
          if (run_inc == WARMUP_LIM) begin
            state_d = ST_ACQUIRE;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        ST_ACQUIRE: begin
          update_d = 1'b1;
          if (phase_mag < ACQ_LIM) begin
            if (run_inc == ACQ_N_LIM) begin
              state_d = ST_TRACK;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end
        ST_TRACK: begin
          update_d = 1'b1;
          if (phase_mag > ACQ_LIM) begin
            state_d = ST_ACQUIRE;
            run_d   = '0;
          end else if (phase_mag < LOCK_LIM) begin
            if (run_inc == LOCK_N_LIM) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          update_d = 1'b1;
          if (phase_mag > ACQ_LIM) begin
            state_d = ST_ACQUIRE;
            run_d   = '0;
          end else if (phase_mag > UNLOCK_LIM) begin
            state_d = ST_TRACK;
            run_d   = '0;
          end
        end
        ST_HOLDOVER: begin
          state_d = ST_ACQUIRE;
          run_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end else if (active_q && timeout_hit) begin
      state_d = ST_HOLDOVER;
      run_d   = '0;
    end
  end

  // Gain only tracks the loop states; holdover keeps whatever gain was last in use.
  always_comb begin
    active_d = (state_d == ST_ACQUIRE) || (state_d == ST_TRACK) || (state_d == ST_LOCKED);
    gain_d   = Pid_Gain_Sel;
    case (state_d)
      ST_ACQUIRE: gain_d = 2'd0;
      ST_TRACK:   gain_d = 2'd1;
      ST_LOCKED:  gain_d = 2'd2;
      default:    gain_d = Pid_Gain_Sel;
    endcase
  end

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      run_q        <= '0;
      timer_q      <= '0;
      Pid_Update   <= 1'b0;
      Phase_Err    <= '0;
      Pid_Gain_Sel <= '0;
      Pid_Hold     <= 1'b1;
      Led_Lock     <= 1'b0;
    end else begin
      run_q        <= run_d;
      timer_q      <= timer_d;
      Pid_Update   <= update_d;
      if (Measure_Done) begin
        Phase_Err <= phase_sat;
      end
      Pid_Gain_Sel <= gain_d;
      Pid_Hold     <= !active_d;
      Led_Lock     <= (state_d == ST_LOCKED);
    end
  end

  assign Loop_State = state_q;

endmodule
